register_operand_fetch: RTL and testbench
=========================================

// Module: register_operand_fetch
// PURPOSE
//  Read-side counterpart of the writeback path: fetches source operands rs1/rs2 from the
//  register file through its single synchronous read port, one operand at a time.
//  Sits between decode and execute; control pulses start, waits for done, then hands
//  rs1_value/rs2_value to the ALU/memory stages. Snoops the write port to forward in-flight writes.
// PARAMETERS
//  XLEN            32  operand/data width
//  REG_ADDR_WIDTH  5   register index width (32 registers, x0 hardwired zero)
// PORTS
//  clk              in   1               clock, all state on rising edge
//  reset            in   1               asynchronous, active-high; one clock domain
//  start            in   1               begin fetch; sampled only in IDLE
//  opcode           in   7               instruction opcode, latched with start
//  rs1 / rs2        in   REG_ADDR_WIDTH  source register indices, latched with start
//  busy             out  1               high in every state except IDLE
//  done             out  1               one-cycle pulse; operands valid from this cycle on
//  rf_read_addr     out  REG_ADDR_WIDTH  register file read address
//  rf_read_data     in   XLEN            read data, valid one cycle after rf_read_addr
//  rf_write_enable  in   1               snooped register file write strobe
//  rf_write_addr    in   REG_ADDR_WIDTH  snooped write index
//  rf_write_data    in   XLEN            snooped write data
//  rs1_value        out  XLEN            fetched rs1 operand, held until next start
//  rs2_value        out  XLEN            fetched rs2 operand, held until next start
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; busy=0, done=0, rf_read_addr=0, rs1_value=rs2_value=0.
//  Operand need from latched opcode:
//   - both:    `RISCV_ALU_OP_REGS, `RISCV_BRANCH, `RISCV_STORE
//   - rs1 only: `RISCV_ALU_OP_IMM, `RISCV_LOAD, `RISCV_JALR
//   - none:    `RISCV_LUI, `RISCV_AUIPC, `RISCV_JAL, and any unknown opcode
//  Unneeded operand is written 0 at start acceptance.
//  FSM:
//   IDLE  -> start=1: latch opcode/rs1/rs2; go ISSUE1 if rs1 needed, else DONE.
//   ISSUE1: rf_read_addr=rs1; -> CAP1.
//   CAP1:   latch rs1_value; rf_read_addr=rs2 if rs2 needed; -> CAP2 if rs2 needed, else DONE.
//   CAP2:   latch rs2_value; -> DONE.
//   DONE:   done=1 for exactly this cycle; -> IDLE.
//  Latency, start sampled at edge k: none -> done in cycle k+1;
//   rs1 only -> done k+3; both -> done k+4. Back-to-back start is accepted the cycle after DONE.
//  start outside IDLE is ignored; held-high start re-triggers only from IDLE.
//  rf_read_addr holds its last value in IDLE/DONE.
//  Forwarding: the register file read is read-before-write.
//   - Per-operand match flag set when the snooped write is seen in the operand's issue cycle
//     with rf_write_enable=1, rf_write_addr==index, index!=0; flag stores rf_write_data.
//   - Capture value priority: matching write in the capture cycle itself > flagged write
//     > rf_read_data.
//  x0: index 0 always captures 0, regardless of rf_read_data or snooped writes; the read may still issue.
//  No arithmetic; all values pass through at XLEN width unmodified.
//  Reset asserted mid-fetch: immediate return to IDLE, outputs cleared, no done pulse;
//   fetch is not resumed after reset.
// TESTING
//  1. ALU_OP_REGS rs1=3 (RF=0x11), rs2=4 (RF=0x22), start at k -> done only at k+4,
//     rs1_value=0x11, rs2_value=0x22, busy high k+1..k+4.
//  2. LUI start -> done at k+1, rf_read_addr unchanged, rs1_value=rs2_value=0.
//  3. LOAD rs1=0 with RF port driving 0xDEADBEEF and write x0<=5 during CAP1 -> rs1_value=0.
//  4. ALU_OP_IMM rs1=7 (RF old=0x1), write x7<=0x99 during ISSUE1 -> rs1_value=0x99;
//     repeat with the write during CAP1 -> rs1_value=0x99; write to x8 -> rs1_value=0x1.
//  5. start pulsed again during CAP1 of a STORE -> ignored, exactly one done, values from first fetch.
//  6. reset asserted in CAP2 of a BRANCH -> same-cycle busy=0, values=0, no done;
//     new fetch after release completes normally.

Source files
------------

// File: rtl/register_operand_fetch.sv
// Operand fetch between decode and execute: reads rs1/rs2 through the
// single synchronous register file read port and forwards snooped writes.
module register_operand_fetch #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [6:0]                opcode,
  input  logic [REG_ADDR_WIDTH-1:0] rs1,
  input  logic [REG_ADDR_WIDTH-1:0] rs2,
  output logic                      busy,
  output logic                      done,
  output logic [REG_ADDR_WIDTH-1:0] rf_read_addr,
  input  logic [XLEN-1:0]           rf_read_data,
  input  logic                      rf_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
  input  logic [XLEN-1:0]           rf_write_data,
  output logic [XLEN-1:0]           rs1_value,
  output logic [XLEN-1:0]           rs2_value
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REGS   = 7'b0110011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE1,
    S_CAP1,
    S_CAP2,
    S_DONE
  } state_t;

  // Returns {need_rs2, need_rs1}
  function automatic logic [1:0] need_of(input logic [6:0] op);
    logic [1:0] n;
    n = 2'b00;
    case (op)
      OP_REGS, OP_BRANCH, OP_STORE: n = 2'b11;
      OP_IMM, OP_LOAD, OP_JALR:     n = 2'b01;
      OP_LUI, OP_AUIPC, OP_JAL:     n = 2'b00;
      default:                      n = 2'b00;
    endcase
    return n;
  endfunction

  state_t                    state_q, state_d;
  logic [6:0]                opcode_q, opcode_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs1_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]           rs1_val_q, rs1_val_d;
  logic [XLEN-1:0]           rs2_val_q, rs2_val_d;
  logic                      fwd1_hit_q, fwd1_hit_d;
  logic                      fwd2_hit_q, fwd2_hit_d;
  logic [XLEN-1:0]           fwd1_data_q, fwd1_data_d;
  logic [XLEN-1:0]           fwd2_data_q, fwd2_data_d;

  logic [1:0] need_start;
  logic [1:0] need_lat;
  logic       wr_hit1;
  logic       wr_hit2;

  assign need_start = need_of(opcode);
  assign need_lat   = need_of(opcode_q);

  assign wr_hit1 = rf_write_enable && (rf_write_addr == rs1_q)
                   && (rs1_q != '0);
  assign wr_hit2 = rf_write_enable && (rf_write_addr == rs2_q)
                   && (rs2_q != '0);

  always_comb begin
    state_d     = state_q;
    opcode_d    = opcode_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    addr_d      = addr_q;
    rs1_val_d   = rs1_val_q;
    rs2_val_d   = rs2_val_q;
    fwd1_hit_d  = fwd1_hit_q;
    fwd2_hit_d  = fwd2_hit_q;
    fwd1_data_d = fwd1_data_q;
    fwd2_data_d = fwd2_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          opcode_d   = opcode;
          rs1_d      = rs1;
          rs2_d      = rs2;
          fwd1_hit_d = 1'b0;
          fwd2_hit_d = 1'b0;
          if (!need_start[0]) rs1_val_d = '0;
          if (!need_start[1]) rs2_val_d = '0;
          if (need_start[0]) begin
            addr_d  = rs1;
            state_d = S_ISSUE1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE1: begin
        if (wr_hit1) begin
          fwd1_hit_d  = 1'b1;
          fwd1_data_d = rf_write_data;
        end
        // Present rs2 during CAP1 so its data lands in CAP2
        if (need_lat[1]) addr_d = rs2_q;
        state_d = S_CAP1;
      end
      S_CAP1: begin
        if (rs1_q == '0)     rs1_val_d = '0;
        else if (wr_hit1)    rs1_val_d = rf_write_data;
        else if (fwd1_hit_q) rs1_val_d = fwd1_data_q;
        else                 rs1_val_d = rf_read_data;
        if (need_lat[1]) begin
          if (wr_hit2) begin
            fwd2_hit_d  = 1'b1;
            fwd2_data_d = rf_write_data;
          end
          state_d = S_CAP2;
        end else begin
          state_d = S_DONE;
        end
      end
      S_CAP2: begin
        if (rs2_q == '0)     rs2_val_d = '0;
        else if (wr_hit2)    rs2_val_d = rf_write_data;
        else if (fwd2_hit_q) rs2_val_d = fwd2_data_q;
        else                 rs2_val_d = rf_read_data;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      opcode_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      addr_q      <= '0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      fwd1_hit_q  <= 1'b0;
      fwd2_hit_q  <= 1'b0;
      fwd1_data_q <= '0;
      fwd2_data_q <= '0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      addr_q      <= addr_d;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      fwd1_hit_q  <= fwd1_hit_d;
      fwd2_hit_q  <= fwd2_hit_d;
      fwd1_data_q <= fwd1_data_d;
      fwd2_data_q <= fwd2_data_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign rf_read_addr = addr_q;
  assign rs1_value    = rs1_val_q;
  assign rs2_value    = rs2_val_q;

endmodule

// File: tb/tb_register_operand_fetch.sv
// Bench for register_operand_fetch: behavioural read-before-write register
// file, expected operands/latency queued at start and popped at done.
module tb_register_operand_fetch;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REGS   = 7'b0110011;

  logic        clk;
  logic        reset;
  logic        start;
  logic [6:0]  opcode;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        busy;
  logic        done;
  logic [4:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic        rf_write_enable;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          errors;
  int          cyc;
  logic [31:0] rf_mem [32];
  logic [4:0]  saved_addr;

  register_operand_fetch #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .opcode          (opcode),
    .rs1             (rs1),
    .rs2             (rs2),
    .busy            (busy),
    .done            (done),
    .rf_read_addr    (rf_read_addr),
    .rf_read_data    (rf_read_data),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .rs1_value       (rs1_value),
    .rs2_value       (rs2_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    rf_read_data <= rf_mem[rf_read_addr];
    if (rf_write_enable) rf_mem[rf_write_addr] <= rf_write_data;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    rf_write_enable = 1'b1;
    rf_write_addr   = a;
    rf_write_data   = d;
    @(negedge clk);
    rf_write_enable = 1'b0;
  endtask

  // w_off/re_off: cycle after the start edge (1=ISSUE1, 2=CAP1, 3=CAP2)
  task automatic run_fetch(input logic [6:0] op, input logic [4:0] a1,
                           input logic [4:0] a2, input logic [31:0] e1,
                           input logic [31:0] e2, input int lat,
                           input int w_off, input logic [4:0] wa,
                           input logic [31:0] wd, input int re_off);
    exp_t e;
    int   c0;
    bit   seen;
    @(negedge clk);
    e.r1  = e1;
    e.r2  = e2;
    e.lat = lat;
    sb.push_back(e);
    opcode = op;
    rs1    = a1;
    rs2    = a2;
    start  = 1'b1;
    c0     = cyc;
    seen   = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      start           = 1'b0;
      rf_write_enable = 1'b0;
      if (done) begin
        e = sb.pop_front();
        chk("latency", 32'(cyc - c0), 32'(e.lat));
        chk("busy_at_done", {31'd0, busy}, 32'd1);
        chk("rs1_value", rs1_value, e.r1);
        chk("rs2_value", rs2_value, e.r2);
        seen = 1'b1;
        break;
      end
      chk("busy", {31'd0, busy}, 32'd1);
      if (n == w_off) begin
        rf_write_enable = 1'b1;
        rf_write_addr   = wa;
        rf_write_data   = wd;
      end
      if (n == re_off) begin
        start  = 1'b1;
        opcode = OP_LUI;
        rs1    = 5'd9;
        rs2    = 5'd10;
      end
    end
    start           = 1'b0;
    rf_write_enable = 1'b0;
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    @(negedge clk);
    chk("done_single", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int c0;
    checks          = 0;
    errors          = 0;
    cyc             = 0;
    reset           = 1'b1;
    start           = 1'b0;
    opcode          = '0;
    rs1             = '0;
    rs2             = '0;
    rf_write_enable = 1'b0;
    rf_write_addr   = '0;
    rf_write_data   = '0;
    for (int i = 0; i < 32; i++) rf_mem[i] = 32'h100 + 32'(i);
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_addr", {27'd0, rf_read_addr}, 32'd0);
    chk("rst_rs1", rs1_value, 32'd0);
    chk("rst_rs2", rs2_value, 32'd0);
    reset = 1'b0;

    poke(5'd3, 32'h11);
    poke(5'd4, 32'h22);
    poke(5'd0, 32'hDEADBEEF);

    run_fetch(OP_REGS, 5'd3, 5'd4, 32'h11, 32'h22, 4, 0, 5'd0, 0, 0);

    saved_addr = rf_read_addr;
    run_fetch(OP_LUI, 5'd5, 5'd6, 32'd0, 32'd0, 1, 0, 5'd0, 0, 0);
    chk("lui_addr_hold", {27'd0, rf_read_addr}, {27'd0, saved_addr});
    run_fetch(OP_AUIPC, 5'd3, 5'd4, 32'd0, 32'd0, 1, 0, 5'd0, 0, 0);
    run_fetch(7'h7f, 5'd3, 5'd4, 32'd0, 32'd0, 1, 0, 5'd0, 0, 0);

    run_fetch(OP_LOAD, 5'd0, 5'd4, 32'd0, 32'd0, 3, 2, 5'd0, 32'd5, 0);

    poke(5'd7, 32'h1);
    run_fetch(OP_IMM, 5'd7, 5'd4, 32'h99, 32'd0, 3, 1, 5'd7, 32'h99, 0);
    poke(5'd7, 32'h1);
    run_fetch(OP_IMM, 5'd7, 5'd4, 32'h99, 32'd0, 3, 2, 5'd7, 32'h99, 0);
    poke(5'd7, 32'h1);
    run_fetch(OP_IMM, 5'd7, 5'd4, 32'h1, 32'd0, 3, 1, 5'd8, 32'h99, 0);

    run_fetch(OP_REGS, 5'd3, 5'd4, 32'h11, 32'h44, 4, 2, 5'd4, 32'h44, 0);
    run_fetch(OP_BRANCH, 5'd3, 5'd4, 32'h11, 32'h55, 4, 3, 5'd4, 32'h55, 0);
    run_fetch(OP_JALR, 5'd4, 5'd3, 32'h55, 32'd0, 3, 0, 5'd0, 0, 0);

    run_fetch(OP_STORE, 5'd3, 5'd4, 32'h11, 32'h55, 4, 0, 5'd0, 0, 2);
    repeat (3) begin
      @(negedge clk);
      chk("no_retrigger", {30'd0, busy, done}, 32'd0);
    end

    @(negedge clk);
    opcode = OP_BRANCH;
    rs1    = 5'd3;
    rs2    = 5'd4;
    start  = 1'b1;
    c0     = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_cyc", 32'(cyc - c0), 32'd3);
    chk("pre_rst_rs1", rs1_value, 32'h11);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_rs1", rs1_value, 32'd0);
    chk("mid_rst_rs2", rs2_value, 32'd0);
    chk("mid_rst_addr", {27'd0, rf_read_addr}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_quiet", {30'd0, busy, done}, 32'd0);
    end
    run_fetch(OP_JAL, 5'd3, 5'd4, 32'd0, 32'd0, 1, 0, 5'd0, 0, 0);
    run_fetch(OP_BRANCH, 5'd3, 5'd4, 32'h11, 32'h55, 4, 0, 5'd0, 0, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
